booth_pp_accum: RTL and testbench
=================================

# booth_pp_accum

Sequential partial-product accumulator that sits directly downstream of the radix-4 Booth encoder in the 3-mult datapath. It accepts the encoder's four signed partial products in one handshake. It sums them one per clock with the correct 2-bit weight shifts and presents the full MBITS+NBITS signed product through a valid/ready output. It is the area-lean alternative to the combinational Wallace tree and has the same arithmetic result.

## Interface
- MBITS, 12, multiplicand width; must match the encoder and alu.v's MBITS
- NBITS, 8, multiplier width; must be even
- NPP, NBITS/2, number of Booth partial products
- PPBITS, MBITS+2, signed width of each partial product; holds ±2·mpd without overflow
- PBITS, MBITS+NBITS, product width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  upstream has a partial-product set
- in_ready  out  1  block can accept; high only in IDLE with reset low
- pp_in  in  NPP·PPBITS  packed partial products; pp_i is bits [i·PPBITS +: PPBITS], pp0 is least significant, two's complement
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  product is valid
- out_ready  in  1  downstream consumes the product
- product  out  PBITS  signed product, two's complement

## Operation
- States and transitions:
  - IDLE → ACCUM on in_valid && in_ready.
  - ACCUM → DONE after the NPP-th add.
  - DONE → IDLE on out_ready.
- Accept edge: latch pp_in into an internal register, clear acc to 0, set idx to 0.
- ACCUM, each edge: acc ← acc + (sext_PBITS(pp[idx]) << 2·idx), truncated to PBITS bits, then idx ← idx+1.
- Last add (idx = NPP−1): write the summed value into both acc and product, set out_valid to 1, go to DONE.
- DONE:
  - out_valid and product are held stable.
  - in_ready is 0.
  - When out_ready is sampled high at an edge: out_valid ← 0, go to IDLE.
  - product keeps its last value.
- Arithmetic:
  - The sum of valid Booth partial products always fits in PBITS signed bits.
  - Any wrap is modulo 2^PBITS. No saturation and no overflow flag.
- in_valid while in_ready is 0 is ignored; upstream holds its data.
- pp_in is sampled only on the accept edge. Changes during ACCUM or DONE have no effect.
- No accept in the same edge as the DONE→IDLE handshake.
- Reset: takes effect immediately when asserted, including mid-ACCUM or mid-DONE.
  - Outputs go to: state IDLE, acc 0, idx 0, product 0, out_valid 0, busy 0, in_ready 0 while reset is high.
  - The in-flight operation is discarded.

## Timing
- Accept at edge E0. Adds happen at E1..ENPP.
- out_valid is high from edge ENPP onward; this is E4 at default parameters.
- With out_ready already high, the handshake completes at E5, IDLE is reached at E5, and the next accept can occur at E6.
- Maximum throughput is one product per NPP+2 cycles (6 at default parameters).
- in_ready and busy are decoded from registered state, so there is no combinational in→out path.
- out_valid and product are registered outputs.

## Structure
- Shared header booth_params.vh holds MBITS, NBITS, NPP, PPBITS, PBITS and the state encodings IDLE, ACCUM, DONE. The encoder and this block both include it.
- One sub-module, booth_pp_align (combinational): selects pp[idx], sign-extends it to PBITS and shifts it left by 2·idx.
- The FSM, idx counter, acc adder and output registers live in booth_pp_accum.

## Test plan
- Basic sum: pp0 = 14'h3FFB (−5), pp1 = 14'h0005, pp2 = pp3 = 0, i.e. mpd = 5, mpr = 3.
  - Expect product = 20'h0000F.
  - out_valid rises 4 edges after the accept edge.
- Most-negative operands: pp3 = 14'h1000 (+4096), other pp = 0, i.e. mpd = −2048, mpr = −128.
  - Expect product = 20'h40000.
- Large negative result: pp3 = 14'h3002 (−4094), other pp = 0, i.e. mpd = 2047, mpr = −128.
  - Expect product = 20'hC0080.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid, with in_valid = 1 and new pp_in.
  - Expect out_valid, product, busy and in_ready = 0 all stable, and the new data not accepted.
  - Raise out_ready: IDLE next edge, then the new set is accepted.
- Reset mid-operation: assert reset after 2 ACCUM edges.
  - Expect out_valid, busy and product = 0 immediately, without waiting for a clock.
  - After release, an accept with the basic-sum set gives 20'h0000F.
- Streaming: in_valid and out_ready held high with random valid Booth sets.
  - Expect an accept exactly every 6 cycles.
  - Every product matches a reference signed 12×8 multiply.

Source files
------------

// File: rtl/booth_pp_accum_pkg.sv
// Shared widths and FSM encoding for the radix-4 Booth partial-product accumulator.
// The Booth encoder upstream uses the same widths.
package booth_pp_accum_pkg;

    localparam int MBITS  = 12;
    localparam int NBITS  = 8;
    localparam int NPP    = NBITS / 2;
    localparam int PPBITS = MBITS + 2;
    localparam int PBITS  = MBITS + NBITS;
    localparam int IDXW   = (NPP > 1) ? $clog2(NPP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/booth_pp_align.sv
// Selects one Booth partial product, sign-extends it to product width and applies its
// radix-4 weight (shift by 2*idx).
module booth_pp_align
    import booth_pp_accum_pkg::*;
(
    input  logic [NPP*PPBITS-1:0] pp_all_i,
    input  logic [IDXW-1:0]       idx_i,
    output logic [PBITS-1:0]      term_o
);

    logic signed [PPBITS-1:0] sel;
    logic signed [PBITS-1:0]  ext;

    always_comb begin
        sel    = pp_all_i[int'(idx_i)*PPBITS +: PPBITS];
        ext    = {{(PBITS-PPBITS){sel[PPBITS-1]}}, sel};
        term_o = ext <<< {idx_i, 1'b0};
    end

endmodule

// File: rtl/booth_pp_accum.sv
// Sequential accumulator for radix-4 Booth partial products: one add per clock,
// product presented through a valid/ready handshake. Wraps modulo 2^PBITS.
module booth_pp_accum
    import booth_pp_accum_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NPP*PPBITS-1:0] pp_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PBITS-1:0]      product
);

    state_t                state_q;
    logic [IDXW-1:0]       idx_q;
    logic [PBITS-1:0]      acc_q;
    logic [PBITS-1:0]      acc_d;
    logic [PBITS-1:0]      term;
    logic [PBITS-1:0]      product_q;
    logic                  out_valid_q;
    logic [NPP*PPBITS-1:0] pp_q;

    booth_pp_align u_align (
        .pp_all_i (pp_q),
        .idx_i    (idx_q),
        .term_o   (term)
    );

    assign acc_d = acc_q + term;

    // Operand capture: data only, no reset needed; only the accept edge loads it.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            pp_q <= pp_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDXW'(NPP-1)) begin
                        product_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // No accept on this edge: IDLE is entered first, accept follows.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Bench for booth_pp_accum: directed vector table, backpressure and reset corner cases,
// and a randomized stream checked against a plain signed multiply.
module tb_booth_pp_accum;
    import booth_pp_accum_pkg::*;

    localparam int PPW = NPP * PPBITS;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [PPW-1:0]   pp_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [PBITS-1:0] product;

    int checks;
    int errors;

    booth_pp_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp_in     (pp_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PPW-1:0]   pp;
        logic [PBITS-1:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference Booth recoding from the multiplier bits: digit = -2*b(2i+1) + b(2i) + b(2i-1).
    function automatic logic [PPW-1:0] booth_set(input int mpd, input int mpr);
        logic [PPW-1:0]    s;
        logic [PPBITS-1:0] t;
        int b1, b0, bm1, digit;
        s = '0;
        for (int i = 0; i < NPP; i++) begin
            b1    = (mpr >>> (2*i+1)) & 1;
            b0    = (mpr >>> (2*i)) & 1;
            bm1   = (i == 0) ? 0 : ((mpr >>> (2*i-1)) & 1);
            digit = -2*b1 + b0 + bm1;
            t     = PPBITS'(digit * mpd);
            s[i*PPBITS +: PPBITS] = t;
        end
        return s;
    endfunction

    function automatic logic [PBITS-1:0] ref_prod(input int mpd, input int mpr);
        return PBITS'(mpd * mpr);
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [PPW-1:0] pp, input logic [PBITS-1:0] exp);
        int lat;
        wait_ready(name);
        in_valid = 1'b1;
        pp_in    = pp;
        step();
        in_valid = 1'b0;
        pp_in    = '0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(NPP));
        check({name, "_product"}, 32'(product), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_ovalid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    localparam logic [PPW-1:0]   PP_BASIC  = {14'h0000, 14'h0000, 14'h0005, 14'h3FFB};
    localparam logic [PPW-1:0]   PP_MOSTN  = {14'h1000, 14'h0000, 14'h0000, 14'h0000};
    localparam logic [PPW-1:0]   PP_LARGEN = {14'h3002, 14'h0000, 14'h0000, 14'h0000};

    vec_t             vecs [8];
    logic [PBITS-1:0] exp_q [$];
    logic [PBITS-1:0] pend_exp;
    logic [PBITS-1:0] held;
    int               mpd, mpr;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp_in     = '0;

        vecs[0] = '{PP_BASIC,  20'h0000F};
        vecs[1] = '{PP_MOSTN,  20'h40000};
        vecs[2] = '{PP_LARGEN, 20'hC0080};
        vecs[3] = '{booth_set(-2048, 127),  ref_prod(-2048, 127)};
        vecs[4] = '{booth_set(2047, -128),  ref_prod(2047, -128)};
        vecs[5] = '{booth_set(0, -77),      ref_prod(0, -77)};
        vecs[6] = '{booth_set(-1, -1),      ref_prod(-1, -1)};
        vecs[7] = '{booth_set(-2048, -1),   ref_prod(-2048, -1)};

        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].pp, vecs[i].exp);
        end

        // Backpressure: product held in DONE, new set presented but not taken.
        run_op("bp_pre", PP_BASIC, 20'h0000F);
        wait_ready("bp");
        in_valid = 1'b1;
        pp_in    = PP_BASIC;
        step();
        pp_in = PP_MOSTN;
        for (int i = 0; i < 12 && !out_valid; i++) step();
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        held = product;
        check("bp_product", 32'(held), 32'h0000F);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_product", 32'(product), 32'(held));
            check("bp_hold_busy", 32'(busy), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_idle", 32'(busy), 32'd0);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_product_kept", 32'(product), 32'(held));
        step();
        in_valid = 1'b0;
        check("bp_new_accept", 32'(busy), 32'd1);
        for (int i = 0; i < 12 && !out_valid; i++) step();
        check("bp_new_product", 32'(product), 32'h40000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset asserted mid-accumulation, between clock edges.
        wait_ready("rst_mid");
        in_valid = 1'b1;
        pp_in    = PP_LARGEN;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        check("rst_mid_product_before", 32'(product), 32'h40000);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_product", 32'(product), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        run_op("rst_after", PP_BASIC, 20'h0000F);

        // Randomized stream with both handshakes held high.
        begin
            int ncyc, last_acc, nacc, nout;
            logic acc_now;
            ncyc = 0; last_acc = 0; nacc = 0; nout = 0;
            mpd = int'($urandom_range(0, 4095)) - 2048;
            mpr = int'($urandom_range(0, 255)) - 128;
            pp_in     = booth_set(mpd, mpr);
            pend_exp  = ref_prod(mpd, mpr);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            while (nout < 20 && ncyc < 400) begin
                acc_now = in_ready && in_valid;
                step();
                ncyc++;
                if (acc_now) begin
                    if (nacc > 0) check("stream_interval", 32'(ncyc - last_acc), 32'(NPP + 2));
                    last_acc = ncyc;
                    nacc++;
                    exp_q.push_back(pend_exp);
                    mpd = int'($urandom_range(0, 4095)) - 2048;
                    mpr = int'($urandom_range(0, 255)) - 128;
                    pp_in    = booth_set(mpd, mpr);
                    pend_exp = ref_prod(mpd, mpr);
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("stream_unexpected_output", 32'(out_valid), 32'd0);
                    end else begin
                        check("stream_product", 32'(product), 32'(exp_q.pop_front()));
                    end
                    nout++;
                end
            end
            check("stream_count", 32'(nout), 32'd20);
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
